// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, state encoding and clog2 for the FIFO write arbiter
package fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Occupancy must represent 0..depth inclusive, hence the extra bit.
  function automatic int level_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? clog2(num_req) : 1;
  endfunction

  // Beat counter spans 0..burst_len inclusive.
  function automatic int beat_width(input int burst_len);
    return (burst_len > 0) ? clog2(burst_len + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Ports:
//   req   - per-requester request vector
//   ptr   - highest-priority index, 0..NUM_REQ-1
//   gnt   - one-hot first requester at or after ptr (wrapping), else 0
//   valid - any requester is set
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;

  // Wrap by subtracting NUM_REQ so non-power-of-two counts work.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
        sum = sum - (PTR_W + 1)'(NUM_REQ);
      end
      cand = sum[PTR_W-1:0];
      if (!valid && req[cand]) begin
        gnt[cand] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-low reset
//   req, req_data     - per-requester request and data (slice i at i*DATA_WIDTH)
//   gnt               - registered one-hot owner, or 0
//   fifo_wr_en/data   - write strobe and owner's data to the FIFO
//   fifo_rd_en        - consumer read strobe, observed for occupancy
//   level/full/empty  - words stored and derived flags
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 2,
  parameter int LVL_W      = level_width(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_rd_en,
  output logic [LVL_W-1:0]              level,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W  = ptr_width(NUM_REQ);
  localparam int BEAT_W = beat_width(BURST_LEN);

  state_t             state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   owner, owner_n;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   owner_next;
  logic [BEAT_W-1:0]  beats, beats_n;
  logic [NUM_REQ-1:0] gnt_n, pick_gnt;
  logic               pick_valid;
  logic               accept;
  logic               rd_eff;
  logic [LVL_W-1:0]   level_n;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  assign owner_next = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // A stalled burst (full) holds gnt and beats; only a dropped req or the
  // final accepted beat releases the port.
  assign accept     = (state == ST_BURST) && req[owner] && !full;
  assign fifo_wr_en = accept;

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    ptr_n   = ptr;
    beats_n = beats;
    case (state)
      ST_IDLE: begin
        if (pick_valid && !full) begin
          state_n = ST_BURST;
          gnt_n   = pick_gnt;
          owner_n = pick_idx;
          beats_n = '0;
        end
      end
      ST_BURST: begin
        if (accept) begin
          beats_n = beats + 1'b1;
        end
        if (!req[owner] || (accept && (beats_n == BEAT_W'(BURST_LEN)))) begin
          state_n = ST_IDLE;
          gnt_n   = '0;
          ptr_n   = owner_next;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // Reads on an empty FIFO are ignored so level never underflows.
  assign rd_eff = fifo_rd_en && !empty;

  always_comb begin
    level_n = level;
    if (fifo_wr_en && !rd_eff) begin
      level_n = level + 1'b1;
    end else if (rd_eff && !fifo_wr_en) begin
      level_n = level - 1'b1;
    end
  end

  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      beats <= '0;
      level <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      beats <= beats_n;
      level <= level_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  gnt;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_rd_en = 1'b0;
  logic [2:0]  level;
  logic        full;
  logic        empty;

  int checks = 0;
  int failures = 0;

  fifo_wr_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .FIFO_DEPTH (4),
    .BURST_LEN  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .level        (level),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req = 4'b0000;
    fifo_rd_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req = 4'b0000;
    fifo_rd_en = 1'b0;
    tick();
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_low_gnt actual=%b expected=0000", gnt); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_low_empty actual=%b expected=1", empty); end
    reset = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt actual=%b expected=0000", gnt); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level actual=%0d expected=0", level); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty actual=%b expected=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full actual=%b expected=0", full); end
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en actual=%b expected=0", fifo_wr_en); end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_gnt [8];
    logic [7:0] exp_data [8];
    int writes;
    exp_gnt  = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001};
    exp_data = '{8'h11, 8'h11, 8'h00, 8'h33, 8'h33, 8'h00, 8'h11, 8'h11};
    writes = 0;
    do_reset();
    req_data = 32'h44332211;
    req = 4'b0101;
    fifo_rd_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      checks++; if (gnt !== exp_gnt[t]) begin failures++; $display("FAIL fair_gnt[%0d] actual=%b expected=%b", t, gnt, exp_gnt[t]); end
      checks++; if (fifo_wr_data !== exp_data[t]) begin failures++; $display("FAIL fair_data[%0d] actual=%h expected=%h", t, fifo_wr_data, exp_data[t]); end
      checks++; if ((level <= 3'd1) !== 1'b1) begin failures++; $display("FAIL fair_level[%0d] actual=%0d expected<=1", t, level); end
      if (fifo_wr_en === 1'b1) writes++;
    end
    checks++; if (writes != 6) begin failures++; $display("FAIL fair_writes actual=%0d expected=6", writes); end
    req = 4'b0000;
    fifo_rd_en = 1'b0;
  endtask

  task automatic test_fill_stall;
    logic [3:0] exp_gnt [7];
    logic [2:0] exp_lvl [7];
    logic       exp_wr  [7];
    exp_gnt = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    exp_lvl = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_wr  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    req_data = 32'h0000A000;
    req = 4'b0010;
    for (int t = 0; t < 7; t++) begin
      tick();
      checks++; if (gnt !== exp_gnt[t]) begin failures++; $display("FAIL fill_gnt[%0d] actual=%b expected=%b", t, gnt, exp_gnt[t]); end
      checks++; if (level !== exp_lvl[t]) begin failures++; $display("FAIL fill_level[%0d] actual=%0d expected=%0d", t, level, exp_lvl[t]); end
      checks++; if (fifo_wr_en !== exp_wr[t]) begin failures++; $display("FAIL fill_wr_en[%0d] actual=%b expected=%b", t, fifo_wr_en, exp_wr[t]); end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full actual=%b expected=1", full); end
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL drain_level actual=%0d expected=3", level); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL drain_gnt actual=%b expected=0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL refill_gnt actual=%b expected=0010", gnt); end
    checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL refill_wr_en actual=%b expected=1", fifo_wr_en); end
    checks++; if (fifo_wr_data !== 8'hA0) begin failures++; $display("FAIL refill_data actual=%h expected=a0", fifo_wr_data); end
    tick();
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL stall_level actual=%0d expected=4", level); end
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL stall_gnt actual=%b expected=0010", gnt); end
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL stall_wr_en actual=%b expected=0", fifo_wr_en); end
    tick();
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL stall2_level actual=%0d expected=4", level); end
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL stall2_gnt actual=%b expected=0010", gnt); end
    req = 4'b0000;
  endtask

  task automatic test_simultaneous;
    do_reset();
    req_data = 32'h000000B1;
    req = 4'b0001;
    for (int t = 0; t < 4; t++) tick();
    checks++; if (level !== 3'd2) begin failures++; $display("FAIL sim_pre_level actual=%0d expected=2", level); end
    checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL sim_pre_wr_en actual=%b expected=1", fifo_wr_en); end
    fifo_rd_en = 1'b1;
    tick();
    checks++; if (level !== 3'd2) begin failures++; $display("FAIL sim_level actual=%0d expected=2", level); end
    req = 4'b0000;
    tick();
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL sim_drain_level actual=%0d expected=1", level); end
    tick();
    tick();
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL empty_read_level actual=%0d expected=0", level); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL empty_read_empty actual=%b expected=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL empty_read_full actual=%b expected=0", full); end
    fifo_rd_en = 1'b0;
  endtask

  task automatic test_early_release;
    do_reset();
    req_data = 32'h00C20000;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL early_gnt actual=%b expected=0100", gnt); end
    checks++; if (fifo_wr_data !== 8'hC2) begin failures++; $display("FAIL early_data actual=%h expected=c2", fifo_wr_data); end
    tick();
    req = 4'b0000;
    #1;
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL early_drop_wr_en actual=%b expected=0", fifo_wr_en); end
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL early_release_gnt actual=%b expected=0000", gnt); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL early_level actual=%0d expected=1", level); end
    req_data = 32'hD4C3B2A1;
    req = 4'b1111;
    tick();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL early_next_gnt actual=%b expected=1000", gnt); end
    checks++; if (fifo_wr_data !== 8'hD4) begin failures++; $display("FAIL early_next_data actual=%h expected=d4", fifo_wr_data); end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    req_data = 32'h00005A00;
    req = 4'b0010;
    tick();
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL mid_pre_gnt actual=%b expected=0010", gnt); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL mid_pre_level actual=%0d expected=1", level); end
    reset = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL mid_gnt actual=%b expected=0000", gnt); end
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL mid_wr_en actual=%b expected=0", fifo_wr_en); end
    checks++; if (fifo_wr_data !== 8'h00) begin failures++; $display("FAIL mid_data actual=%h expected=00", fifo_wr_data); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL mid_level actual=%0d expected=0", level); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_empty actual=%b expected=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL mid_full actual=%b expected=0", full); end
    tick();
    reset = 1'b1;
    req_data = 32'h44332211;
    req = 4'b1111;
    tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL mid_after_gnt actual=%b expected=0001", gnt); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL mid_after_level actual=%0d expected=0", level); end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_fill_stall();
    test_simultaneous();
    test_early_release();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write port between `NUM_REQ` requesters. It grants bursts of up to `BURST_LEN` words per requester and drives the FIFO's `wr_en`/`wr_data`. It tracks occupancy from its own writes and the consumer's reads to produce exact `level`/`full`/`empty` flags. It sits in front of the FIFO write side, in the same clock domain as the consumer.

## Interface
Parameters:
- `DATA_WIDTH`, 1, word width.
- `NUM_REQ`, 4, number of requesters, ≥2.
- `FIFO_DEPTH`, 4, capacity of the downstream FIFO in words.
- `BURST_LEN`, 2, maximum accepted words per grant, ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state clears while low.
- `req`  in  NUM_REQ  per-requester write request.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`  out  NUM_REQ  one-hot current owner, or all zero.
- `fifo_wr_en`  out  1  write strobe to the FIFO.
- `fifo_wr_data`  out  DATA_WIDTH  owner's `req_data` slice.
- `fifo_rd_en`  in  1  consumer read strobe, observed only.
- `level`  out  clog2(FIFO_DEPTH)+1  words currently stored.
- `full`  out  1  `level == FIFO_DEPTH`.
- `empty`  out  1  `level == 0`.

## Operation
- Two-state FSM, `IDLE` and `BURST`, with a round-robin pointer `ptr` (0..NUM_REQ-1) and a beat counter `beats` (0..BURST_LEN).
- `IDLE`:
  - If any `req` is set and `!full`, pick the first requesting index at or after `ptr`, wrapping modulo NUM_REQ.
  - Register the one-hot `gnt`, clear `beats`, go to `BURST`.
  - Otherwise stay in `IDLE` with `gnt` = 0.
- `BURST`, owner o:
  - Accept = `req[o] & !full`, combinational.
  - `fifo_wr_en` = accept.
  - `fifo_wr_data` = slice o, driven whenever `gnt` is nonzero, otherwise 0.
  - On accept, `beats` increments.
- Leave `BURST` for `IDLE` when `beats` reaches BURST_LEN (the cycle of the last accept) or when `req[o]` is low. On leaving:
  - `gnt` goes to 0.
  - `ptr` becomes (o+1) mod NUM_REQ.
- `full` during `BURST`: the burst stalls. `gnt` is held, `beats` is held, and nothing is written.
- A requester must hold `req_data` stable while its `req` and `gnt` are both high. Dropping `req` ends the burst with no penalty.
- Occupancy:
  - `level` increments on `fifo_wr_en`.
  - `level` decrements on `fifo_rd_en & !empty`.
  - Both in the same cycle leave it unchanged.
  - `fifo_rd_en` while empty is ignored.
  - Writes never occur while full, so `level` never exceeds FIFO_DEPTH.
- Arithmetic: the pointer wraps at NUM_REQ, not at a power of two. `level` is unsigned with no wrap.

## Timing
- Reset values (asynchronous, immediate):
  - State `IDLE`, `ptr` = 0, `beats` = 0.
  - `gnt` = 0, `fifo_wr_en` = 0, `fifo_wr_data` = 0.
  - `level` = 0, `empty` = 1, `full` = 0.
- Reset asserted mid-burst aborts the burst. A write in flight in that cycle is not counted.
- Latency from `req` to `gnt` is one cycle. The first write happens in the first `gnt` cycle if `!full`.
- There is one mandatory `IDLE` cycle between consecutive bursts, including back-to-back bursts by the same single requester.
- `level`, `full` and `empty` are registered and update one cycle after the strobe.
- `fifo_wr_en` and `fifo_wr_data` are combinational from registered `gnt`, `req` and `full`.

## Structure
- Shared package/include `fifo_pkg`: `clog2` function, state encodings `ST_IDLE` = 0 and `ST_BURST` = 1. `FIFO_DEPTH`-derived widths are computed from `clog2` there.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are `req` and `ptr`; outputs are a one-hot grant and a `valid` flag. It is parameterised by NUM_REQ.
- The top level holds the FSM, beat counter, pointer update, occupancy counter and data mux.

## Test plan
All scenarios use NUM_REQ=4, FIFO_DEPTH=4, BURST_LEN=2, DATA_WIDTH=8.
- Reset: hold `reset` low, then release with `req` = 0 → `gnt` = 0000, `level` = 0, `empty` = 1, `full` = 0, `fifo_wr_en` = 0.
- Fairness: `req` = 0101 held, `fifo_rd_en` = 1 constant → `gnt` sequence 0001, 0001, 0000, 0100, 0100, 0000, 0001…, with two writes per grant and `level` staying ≤1.
- Fill and stall: `req[1]` held with data 0xA0, no reads.
  - Expected: 4 writes over two bursts, then `full` = 1, `level` = 4, and `gnt` stays 0000 in `IDLE`.
  - Then one `fifo_rd_en` pulse → `level` = 3, `gnt` = 0010 next cycle, then one write, `level` = 4.
- Simultaneous events: at `level` = 2, a write and `fifo_rd_en` in the same cycle → `level` remains 2. `fifo_rd_en` at `level` = 0 → `level` 0, `empty` 1.
- Early release: `req[2]` drops after one accepted beat → `gnt` = 0000 next cycle and `ptr` = 3. `req` = 1111 then grants 1000.
- Reset mid-burst: pull `reset` low while `gnt` = 0010 and `beats` = 1 → all outputs at reset values immediately. After release, `req` = 1111 grants 0001.
